// File: rtl/qft3_pipe_ctrl_pkg.sv
// Shared fixed-point parameter header for the QFT3 pipeline controller slice.
package qft3_pipe_ctrl_pkg;

    // 16 complex amplitudes, each TOTAL_WIDTH bits in the flattened result vector
    localparam int unsigned AMP_COUNT   = 16;
    localparam int unsigned TOTAL_WIDTH = 8;
    localparam int unsigned QFT_DATA_W  = AMP_COUNT * TOTAL_WIDTH;

    // Capture-to-result latency of the free-running QFT datapath
    localparam int unsigned QFT_LATENCY = 26;

    // Per-edge operation applied to the result FIFO
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/qft3_pipe_ctrl_result_fifo.sv
// Result FIFO: power-of-two ring buffer with occupancy count and drop flag.
module qft3_result_fifo
    import qft3_pipe_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wr_data,
    output logic                           rd_valid,
    output logic [WIDTH-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           drop
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;
    fifo_op_e         op;

    assign rd_valid = (count != '0);
    assign full     = (count == CW'(DEPTH));
    // Head is forced to zero when empty so reset/flush present clean outputs
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Decode the edge operation; a push into a full FIFO only lands if the head leaves too
    always_comb begin
        do_pop  = pop & rd_valid;
        do_push = push & (~full | do_pop);
        drop    = push & full & ~do_pop & ~clr;
        op      = FIFO_IDLE;
        if (do_push && do_pop)
            op = FIFO_BOTH;
        else if (do_push)
            op = FIFO_PUSH;
        else if (do_pop)
            op = FIFO_POP;
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            unique case (op)
                FIFO_PUSH: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                end
                FIFO_POP: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
                FIFO_BOTH: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Storage array, written at the tail on an accepted push
    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/qft3_pipe_ctrl.sv
// QFT3 pipeline controller: credit-based admission, valid/tag delay line
// matching the datapath latency, and capture of results into a FIFO.
module qft3_pipe_ctrl
    import qft3_pipe_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = QFT_LATENCY,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DATA_W  = QFT_DATA_W,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            res_data,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [TAG_W-1:0]             out_tag,
    input  logic                         out_ready,
    output logic [$clog2(LATENCY+1)-1:0] inflight,
    output logic                         ovf_err
);

    localparam int unsigned IW = $clog2(LATENCY+1);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic             vld_line [LATENCY];
    logic [TAG_W-1:0] tag_line [LATENCY];

    logic             accept;
    logic             cap_en;
    logic             pop_ok;
    logic             push_ok;
    logic [IW-1:0]    inflight_nxt;
    logic [CW-1:0]    fifo_cnt_nxt;
    logic             in_ready_nxt;

    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_drop;

    assign accept = in_valid & in_ready & ~flush;
    assign cap_en = vld_line[LATENCY-1];
    assign pop_ok = out_valid & out_ready;

    // Occupancy after this edge: in_ready is registered from these so it
    // reflects accept/pop/capture of the same edge without a comb path to in_valid
    always_comb begin
        push_ok      = cap_en & (~fifo_full | pop_ok);
        inflight_nxt = inflight;
        fifo_cnt_nxt = fifo_count;
        if (flush) begin
            inflight_nxt = '0;
            fifo_cnt_nxt = '0;
        end else begin
            if (accept && !cap_en)
                inflight_nxt = inflight + 1'b1;
            else if (!accept && cap_en)
                inflight_nxt = inflight - 1'b1;
            if (push_ok && !pop_ok)
                fifo_cnt_nxt = fifo_count + 1'b1;
            else if (!push_ok && pop_ok)
                fifo_cnt_nxt = fifo_count - 1'b1;
        end
        in_ready_nxt = (32'(inflight_nxt) + 32'(fifo_cnt_nxt)) < 32'(DEPTH);
    end

    // Valid/tag delay line tracking each accepted sample through the datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                vld_line[i] <= 1'b0;
                tag_line[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                vld_line[i] <= 1'b0;
                tag_line[i] <= '0;
            end
        end else begin
            vld_line[0] <= accept;
            tag_line[0] <= in_tag;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld_line[i] <= vld_line[i-1];
                tag_line[i] <= tag_line[i-1];
            end
        end
    end

    // Credit state, admission flag and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            in_ready <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            inflight <= inflight_nxt;
            in_ready <= in_ready_nxt;
            ovf_err  <= ovf_err | fifo_drop;
        end
    end

    qft3_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + TAG_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (cap_en),
        .pop      (out_ready),
        .wr_data  ({tag_line[LATENCY-1], res_data}),
        .rd_valid (out_valid),
        .rd_data  ({out_tag, out_data}),
        .count    (fifo_count),
        .full     (fifo_full),
        .drop     (fifo_drop)
    );

endmodule

// File: tb/tb_qft3_pipe_ctrl.sv
// Directed and randomized bench for qft3_pipe_ctrl with a tag/data scoreboard.
`timescale 1ns/1ps
module tb_qft3_pipe_ctrl;

    localparam int unsigned LAT = 26;
    localparam int unsigned DEP = 4;
    localparam int unsigned DW  = 128;
    localparam int unsigned TW  = 4;
    localparam int unsigned IW  = $clog2(LAT+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [TW-1:0] in_tag;
    logic          in_ready;
    logic [DW-1:0] res_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic          out_ready;
    logic [IW-1:0] inflight;
    logic          ovf_err;

    int unsigned   cyc;
    int            tests;
    int            fails;
    int            n_acc;
    int            n_pop;
    int            n;
    int            seen;
    int            acc0;

    logic [TW-1:0] q_tag [$];
    logic [DW-1:0] q_data [$];

    always #5 clk = ~clk;

    // Free-running datapath output: a distinct vector every cycle
    function automatic logic [DW-1:0] pattern(input int unsigned c);
        logic [31:0] x;
        x = c;
        return {x * 32'h9E37_79B1, ~x, x ^ 32'hA5A5_5A5A, x + 32'd7};
    endfunction

    assign res_data = pattern(cyc);

    qft3_pipe_ctrl #(
        .LATENCY (LAT),
        .DEPTH   (DEP),
        .DATA_W  (DW),
        .TAG_W   (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .res_data  (res_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ready (out_ready),
        .inflight  (inflight),
        .ovf_err   (ovf_err)
    );

    task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: score the handshakes about to happen, then advance past the edge
    task automatic tick();
        bit acc;
        bit pp;
        acc = in_valid && in_ready && !flush && !rst;
        pp  = out_valid && out_ready && !rst;
        if (pp) begin
            check("sb_nonempty", DW'(q_tag.size() != 0), DW'(1));
            if (q_tag.size() != 0) begin
                check("out_tag", DW'(out_tag), DW'(q_tag.pop_front()));
                check("out_data", out_data, q_data.pop_front());
                n_pop++;
            end
        end
        if (flush || rst) begin
            q_tag.delete();
            q_data.delete();
        end else if (acc) begin
            q_tag.push_back(in_tag);
            q_data.push_back(pattern(cyc + LAT));
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_tag = '0; out_ready = 1'b0;
        cyc = 0; tests = 0; fails = 0; n_acc = 0; n_pop = 0;

        // Reset state
        #1;
        tick(); tick();
        check("rst_in_ready", DW'(in_ready), DW'(0));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data", out_data, DW'(0));
        check("rst_out_tag", DW'(out_tag), DW'(0));
        check("rst_inflight", DW'(inflight), DW'(0));
        check("rst_ovf", DW'(ovf_err), DW'(0));
        rst = 1'b0;
        #1;
        check("in_ready_before_edge", DW'(in_ready), DW'(0));
        tick();
        check("in_ready_after_rst", DW'(in_ready), DW'(1));

        // Single sample latency
        repeat (3) tick();
        out_ready = 1'b1; in_valid = 1'b1; in_tag = 4'd3;
        tick();
        in_valid = 1'b0;
        check("inflight_one", DW'(inflight), DW'(1));
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check("latency_cycles", DW'(n), DW'(LAT));
        check("latency_tag", DW'(out_tag), DW'(3));
        tick();
        check("valid_one_cycle", DW'(out_valid), DW'(0));
        check("sb_empty_single", DW'(q_tag.size()), DW'(0));

        // Backpressure: fill credits with out_ready low
        out_ready = 1'b0; in_valid = 1'b1; acc0 = n_acc;
        for (int i = 0; i < 4; i++) begin
            in_tag = TW'(8 + i);
            tick();
        end
        check("four_accepts", DW'(n_acc - acc0), DW'(4));
        check("in_ready_low_full", DW'(in_ready), DW'(0));
        check("inflight_four", DW'(inflight), DW'(4));
        repeat (36) tick();
        check("still_four_accepts", DW'(n_acc - acc0), DW'(4));
        check("full_out_valid", DW'(out_valid), DW'(1));
        check("full_head_tag", DW'(out_tag), DW'(8));
        check("full_inflight", DW'(inflight), DW'(0));
        check("full_in_ready", DW'(in_ready), DW'(0));
        check("full_ovf", DW'(ovf_err), DW'(0));

        // Single pop frees one credit
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_pop", DW'(in_ready), DW'(1));
        check("head_after_pop", DW'(out_tag), DW'(9));
        in_valid = 1'b1; in_tag = 4'hC;
        tick();
        in_valid = 1'b0;
        check("refill_inflight", DW'(inflight), DW'(1));
        check("refill_in_ready", DW'(in_ready), DW'(0));
        repeat (25) tick();
        check("refill_pre_capture", DW'(inflight), DW'(1));
        tick();
        check("refill_post_capture", DW'(inflight), DW'(0));
        out_ready = 1'b1;
        repeat (8) tick();
        check("drain_empty", DW'(out_valid), DW'(0));
        check("drain_sb_empty", DW'(q_tag.size()), DW'(0));

        // Flush with three in flight
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_tag = TW'(5 + i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        flush = 1'b1; in_valid = 1'b1; in_tag = 4'hF;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_inflight", DW'(inflight), DW'(0));
        check("flush_in_ready", DW'(in_ready), DW'(1));
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        check("flush_no_output", DW'(seen), DW'(0));

        // Reset mid-operation: two buffered, two in flight
        out_ready = 1'b0; in_valid = 1'b1;
        in_tag = 4'd1; tick();
        in_tag = 4'd2; tick();
        in_valid = 1'b0;
        repeat (27) tick();
        check("pre_rst_buffered", DW'(out_valid), DW'(1));
        in_valid = 1'b1;
        in_tag = 4'd3; tick();
        in_tag = 4'd4; tick();
        in_valid = 1'b0;
        tick();
        check("pre_rst_inflight", DW'(inflight), DW'(2));
        #2;
        rst = 1'b1;
        q_tag.delete();
        q_data.delete();
        #1;
        check("mid_rst_in_ready", DW'(in_ready), DW'(0));
        check("mid_rst_out_valid", DW'(out_valid), DW'(0));
        check("mid_rst_out_data", out_data, DW'(0));
        check("mid_rst_out_tag", DW'(out_tag), DW'(0));
        check("mid_rst_inflight", DW'(inflight), DW'(0));
        check("mid_rst_ovf", DW'(ovf_err), DW'(0));
        tick();
        rst = 1'b0;
        check("post_rst_in_ready_low", DW'(in_ready), DW'(0));
        tick();
        check("post_rst_in_ready_high", DW'(in_ready), DW'(1));
        out_ready = 1'b1; seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        check("post_rst_no_output", DW'(seen), DW'(0));

        // Random traffic against the scoreboard
        acc0 = n_pop;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_tag    = TW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (LAT + DEP + 4) tick();
        check("rand_sb_empty", DW'(q_tag.size()), DW'(0));
        check("rand_out_valid", DW'(out_valid), DW'(0));
        check("rand_inflight", DW'(inflight), DW'(0));
        check("rand_ovf", DW'(ovf_err), DW'(0));
        check("rand_made_progress", DW'(n_pop - acc0 > 1000), DW'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qft3_pipe_ctrl.md
QFT3_PIPE_CTRL -- requirements
Module: qft3_pipe_ctrl

Interface
REQ-001 Parameter LATENCY, default 26, cycles from input-register capture edge to result present on res_data.
REQ-002 Parameter DEPTH, default 4, result FIFO entries (power of two, 2..16).
REQ-003 Parameter DATA_W, default 128, flattened 16 amplitudes x TOTAL_WIDTH.
REQ-004 Parameter TAG_W, default 4, sample tag width.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 flush  in  1  synchronous clear of in-flight tracking and FIFO.
REQ-009 in_valid  in  1  upstream sample offered this cycle.
REQ-010 in_tag  in  TAG_W  tag travelling with the sample.
REQ-011 in_ready  out  1  sample accepted at this edge if in_valid also high.
REQ-012 res_data  in  DATA_W  free-running QFT pipeline output vector.
REQ-013 out_valid  out  1  FIFO head holds a result.
REQ-014 out_data  out  DATA_W  FIFO head data.
REQ-015 out_tag  out  TAG_W  FIFO head tag.
REQ-016 out_ready  in  1  downstream pops head at edge when out_valid high.
REQ-017 inflight  out  $clog2(LATENCY+1)  samples in the pipeline.
REQ-018 ovf_err  out  1  sticky: capture attempted into full FIFO.

Function
REQ-019 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-020 in_ready is registered, high iff (inflight + fifo_count) < DEPTH after the current edge's accept/pop/capture updates; in_ready never depends combinationally on in_valid.
REQ-021 A LATENCY-stage valid+tag delay line enters accept at each edge; its last stage is cap_en.
REQ-022 When cap_en is high, res_data and the tag are written to the FIFO tail at that edge; out_valid is high from the following cycle.
REQ-023 End-to-end latency: result accepted at edge k is visible on out_* in the cycle after edge k+LATENCY (LATENCY+1 cycles).
REQ-024 inflight increments on accept, decrements on cap_en; both at one edge leave it unchanged.
REQ-025 Simultaneous pop and capture on a full FIFO is legal; count unchanged, no ovf_err.
REQ-026 Capture into full FIFO without pop: data dropped, ovf_err set until rst.
REQ-027 Pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-028 flush: delay line, inflight, FIFO count/pointers cleared at that edge; in_ready high next cycle; accept in the flush cycle is discarded; ovf_err kept.
REQ-029 Results leave in acceptance order; out_data/out_tag stable while out_valid high and out_ready low.

Reset
REQ-030 On rst: in_ready 0 while asserted, then 1 the first cycle after deassertion; out_valid 0, out_data 0, out_tag 0, inflight 0, ovf_err 0, delay line cleared.
REQ-031 rst mid-operation discards all in-flight and buffered results; nothing emitted afterwards for them.

Structure
REQ-032 LATENCY default, TOTAL_WIDTH and DATA_W derivation live in the shared fixed-point parameter header.
REQ-033 FIFO is one sub-module, qft3_result_fifo (DEPTH, DATA_W+TAG_W, count output); delay line and credit logic stay in the top.

Verification
REQ-034 Single sample tag 3 at edge 10, out_ready=1 -> out_valid with tag 3 in cycle after edge 36, exactly one cycle.
REQ-035 out_ready=0, continuous in_valid -> exactly 4 accepts, in_ready low from cycle after 4th accept; 4 results held, ovf_err 0.
REQ-036 FIFO full, out_ready raised for 1 cycle -> one pop, in_ready high next cycle, next accept emerges 27 cycles later.
REQ-037 Three in flight, flush at edge +5 -> no out_valid within 40 cycles, inflight 0, in_ready 1.
REQ-038 rst pulse with 2 in flight and 2 buffered -> all outputs at reset values, no later emission.
REQ-039 Random in_valid/out_ready 10k cycles -> tags in order, none lost/duplicated, ovf_err 0, reference-model data match.
